// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core.
// Launches, steps, stalls, halts at HALT_PC and faults on bad targets or runaway.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_PC   = 32'd356,
    parameter int unsigned MAX_INSTR = 1024,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      pc,
    output logic             commit,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_FAULT
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_WDOG  = 2'b10;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTR);
    localparam bit CFG_OK = (CNT_W >= $clog2(MAX_INSTR + 1));

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             done_q, done_d;

    logic             at_halt;
    logic             misaligned;
    logic [31:0]      next_pc;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        at_halt    = (pc_q == HALT_PC);
        next_pc    = br_taken ? br_target : pc_q + 32'd4;
        misaligned = br_taken && (br_target[1:0] != 2'b00);
        cnt_inc    = cnt_q + CNT_W'(1);
        commit     = (state_q == S_RUN) && !stall && !at_halt
                     && (!step_mode || step);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pc_d = RESET_PC;
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    err_d   = ERR_NONE;
                end
            end
            S_RUN: begin
                if (stall) begin
                    state_d = S_RUN;
                end else if (at_halt) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if (commit) begin
                    cnt_d = cnt_inc;
                    // A bad target is never loaded; pc stays on the branch.
                    if (misaligned) begin
                        state_d = S_FAULT;
                        err_d   = ERR_ALIGN;
                    end else begin
                        pc_d = next_pc;
                        if (cnt_inc == MAX_CNT && next_pc != HALT_PC) begin
                            state_d = S_FAULT;
                            err_d   = ERR_WDOG;
                        end
                    end
                end
            end
            S_HALTED, S_FAULT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            assert (CFG_OK);
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign pc          = pc_q;
    assign busy        = (state_q == S_RUN);
    assign halted      = (state_q == S_HALTED) || (state_q == S_FAULT);
    assign done        = done_q;
    assign err_code    = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: launch, stall, branch, step, watchdog, reset.
// A second instance with an 8-instruction watchdog shares the stimulus.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;

    logic [31:0] pc;
    logic        commit;
    logic        busy;
    logic        done;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] instr_count;

    logic [31:0] wpc;
    logic        wcommit;
    logic        wbusy;
    logic        wdone;
    logic        whalted;
    logic [1:0]  werr;
    logic [31:0] wcnt;

    int checks;
    int failures;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .commit     (commit),
        .busy       (busy),
        .done       (done),
        .halted     (halted),
        .err_code   (err_code),
        .instr_count(instr_count)
    );

    pc_sequencer #(.MAX_INSTR(8)) dut_wd (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (wpc),
        .commit     (wcommit),
        .busy       (wbusy),
        .done       (wdone),
        .halted     (whalted),
        .err_code   (werr),
        .instr_count(wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_pc", pc, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_commit", {31'd0, commit}, 32'd0);

        // free run to the halt address
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        for (int i = 0; i < 89; i++) begin
            chk("t1_pc", pc, 32'(4 * i));
            chk("t1_commit", {31'd0, commit}, 32'd1);
            tick();
        end
        chk("t1_pc356", pc, 32'd356);
        chk("t1_nocommit", {31'd0, commit}, 32'd0);
        chk("t1_cnt", instr_count, 32'd89);
        chk("t1_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_cnt_h", instr_count, 32'd89);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_halted2", {31'd0, halted}, 32'd1);
        chk("t1_pc_hold", pc, 32'd356);

        // relaunch from HALTED, then stall at pc=8
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_pc0", pc, 32'd0);
        chk("t2_cnt0", instr_count, 32'd0);
        tick();
        tick();
        chk("t2_pc8", pc, 32'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_commit", {31'd0, commit}, 32'd0);
            chk("t2_stall_pc", pc, 32'd8);
            chk("t2_stall_cnt", instr_count, 32'd2);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("t2_commit", {31'd0, commit}, 32'd1);
        tick();
        chk("t2_pc12", pc, 32'd12);
        chk("t2_cnt3", instr_count, 32'd3);

        // taken branch, then misaligned target
        tick();
        chk("t3_pc16", pc, 32'd16);
        br_taken  = 1'b1;
        br_target = 32'h40;
        tick();
        chk("t3_pc40", pc, 32'h40);
        chk("t3_cnt5", instr_count, 32'd5);
        br_target = 32'h42;
        #1;
        chk("t3_mis_commit", {31'd0, commit}, 32'd1);
        tick();
        br_taken = 1'b0;
        chk("t3_err", {30'd0, err_code}, 32'd1);
        chk("t3_halted", {31'd0, halted}, 32'd1);
        chk("t3_pc", pc, 32'h40);
        chk("t3_cnt6", instr_count, 32'd6);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // relaunch from FAULT clears the error
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_rel_pc", pc, 32'd0);
        chk("t6_rel_err", {30'd0, err_code}, 32'd0);
        chk("t6_rel_cnt", instr_count, 32'd0);
        chk("t6_rel_busy", {31'd0, busy}, 32'd1);

        // single-step mode
        step_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_idle_commit", {31'd0, commit}, 32'd0);
            tick();
        end
        chk("t4_pc_held", pc, 32'd0);
        chk("t4_cnt_held", instr_count, 32'd0);
        step = 1'b1;
        #1;
        chk("t4_step_commit", {31'd0, commit}, 32'd1);
        tick();
        step = 1'b0;
        #1;
        chk("t4_gap_commit", {31'd0, commit}, 32'd0);
        chk("t4_pc4", pc, 32'd4);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("t4_pc8", pc, 32'd8);
        chk("t4_cnt2", instr_count, 32'd2);
        step_mode = 1'b0;

        // start ignored in RUN; reset mid-run
        start = 1'b1;
        #1;
        chk("t6_run_commit", {31'd0, commit}, 32'd1);
        tick();
        start = 1'b0;
        chk("t6_start_ign_pc", pc, 32'd12);
        chk("t6_start_ign_cnt", instr_count, 32'd3);
        repeat (22) tick();
        chk("t6_pc100", pc, 32'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_pc", pc, 32'd0);
        chk("t6_rst_cnt", instr_count, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_halted", {31'd0, halted}, 32'd0);
        chk("t6_rst_commit", {31'd0, commit}, 32'd0);

        // watchdog: loop 0 -> 4 -> 0 on the 8-instruction instance
        start = 1'b1;
        tick();
        start = 1'b0;
        br_target = 32'd0;
        for (int i = 0; i < 8; i++) begin
            br_taken = (i % 2 == 1);
            #1;
            chk("t5_wcommit", {31'd0, wcommit}, 32'd1);
            chk("t5_wpc", wpc, (i % 2 == 1) ? 32'd4 : 32'd0);
            if (i == 7) begin
                chk("t5_werr_pre", {30'd0, werr}, 32'd0);
                chk("t5_wcnt_pre", wcnt, 32'd7);
            end
            tick();
        end
        br_taken = 1'b0;
        chk("t5_werr", {30'd0, werr}, 32'd2);
        chk("t5_whalted", {31'd0, whalted}, 32'd1);
        chk("t5_wbusy", {31'd0, wbusy}, 32'd0);
        chk("t5_wcnt", wcnt, 32'd8);
        chk("t5_wpc_end", wpc, 32'd0);
        chk("t5_wdone", {31'd0, wdone}, 32'd0);
        chk("t5_main_err", {30'd0, err_code}, 32'd0);
        chk("t5_main_busy", {31'd0, busy}, 32'd1);
        chk("t5_main_cnt", instr_count, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
